// File: rtl/des_fp_out.sv
// rtl/des_fp_out.sv - DES final permutation with byte-serial ciphertext output
module des_fp_out #(
    parameter bit SWAP_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:32] l16,
    input  logic [1:32] r16,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  byte_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [15:0] blk_cnt
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    // C[i] = P[FP_TAB[i-1]]
    localparam logic [6:0] FP_TAB [64] = '{
        7'd40, 7'd8,  7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
        7'd39, 7'd7,  7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
        7'd38, 7'd6,  7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
        7'd37, 7'd5,  7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
        7'd36, 7'd4,  7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
        7'd35, 7'd3,  7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
        7'd34, 7'd2,  7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
        7'd33, 7'd1,  7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25
    };

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [1:64] hold_q, hold_d;
    logic [15:0] blk_cnt_q, blk_cnt_d;

    logic [1:64] p_pre;
    logic [1:64] c_perm;
    logic [6:0]  byte_base;
    logic        in_xfer;
    logic        out_xfer;
    logic        last_xfer;

    assign p_pre = SWAP_EN ? {r16, l16} : {l16, r16};

    for (genvar g = 0; g < 64; g++) begin : g_fp
        assign c_perm[g+1] = p_pre[FP_TAB[g]];
    end

    assign out_valid = (state_q == SEND);
    assign out_last  = (state_q == SEND) && (idx_q == 3'd7);
    // The only combinational path: a finishing block frees the register for a new one.
    assign in_ready  = (state_q == IDLE) || ((state_q == SEND) && (idx_q == 3'd7) && out_ready);

    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign last_xfer = out_xfer && (idx_q == 3'd7);

    assign byte_base = {1'b0, idx_q, 3'b000} + 7'd1;
    assign byte_out  = hold_q[byte_base +: 8];
    assign blk_cnt   = blk_cnt_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        blk_cnt_d = blk_cnt_q;
        if (last_xfer) begin
            blk_cnt_d = blk_cnt_q + 16'd1;
        end
        if (in_xfer) begin
            hold_d  = c_perm;
            idx_d   = 3'd0;
            state_d = SEND;
        end else if (out_xfer) begin
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            hold_q    <= '0;
            blk_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

endmodule

// File: tb/tb_des_fp_out.sv
// tb/tb_des_fp_out.sv - scoreboard bench for des_fp_out
module tb_des_fp_out;

    logic        clk;
    logic        rst_n;
    logic [1:32] l16;
    logic [1:32] r16;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  byte_out;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [15:0] blk_cnt;

    des_fp_out #(.SWAP_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .l16       (l16),
        .r16       (r16),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .byte_out  (byte_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .blk_cnt   (blk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    logic [8:0]  exp_q [$];
    logic [31:0] bl [4];
    logic [31:0] br [4];
    logic [63:0] bc [4];

    int   cyc        = 0;
    int   xfer_n     = 0;
    int   first_cyc  = 0;
    int   last_cyc   = 0;
    bit   mark_first = 1'b0;
    bit   stall_mode = 1'b0;
    bit   prev_stall = 1'b0;
    logic [7:0] prev_byte;
    logic       prev_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_block(input logic [63:0] c);
        for (int b = 0; b < 8; b++) begin
            exp_q.push_back({(b == 7), c[63-8*b -: 8]});
        end
    endtask

    // Keeps in_valid high across the whole burst so blocks can chain.
    task automatic send_burst(input int n);
        bit ok;
        for (int k = 0; k < n; k++) begin
            l16 = bl[k];
            r16 = br[k];
            in_valid = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (in_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                chk("in_ready_timeout", 64'd0, 64'd1);
                in_valid = 1'b0;
                return;
            end
            push_block(bc[k]);
            @(posedge clk);
            #1;
            chk("latency_out_valid", {63'd0, out_valid}, 64'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int k;
        k = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode) begin
                out_ready = ((k % 3) == 0);
                k++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [8:0] e;
        cyc++;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_byte_hold", {56'd0, byte_out}, {56'd0, prev_byte});
                chk("stall_last_hold", {63'd0, out_last}, {63'd0, prev_last});
            end
            chk("in_ready", {63'd0, in_ready},
                out_valid ? {63'd0, out_last && out_ready} : 64'd1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {56'd0, byte_out}, 64'hdead);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte_out", {56'd0, byte_out}, {56'd0, e[7:0]});
                    chk("out_last", {63'd0, out_last}, {63'd0, e[8]});
                end
                xfer_n++;
                last_cyc = cyc;
                if (mark_first) begin
                    first_cyc  = cyc;
                    mark_first = 1'b0;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_byte  = byte_out;
            prev_last  = out_last;
        end
    end

    initial begin
        int base;
        bit ok;
        rst_n = 1'b0;
        in_valid = 1'b0;
        l16 = '0;
        r16 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_last",  {63'd0, out_last},  64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_byte_out",  {56'd0, byte_out},  64'd0);
        chk("rst_blk_cnt",   {48'd0, blk_cnt},   64'd0);
        rst_n = 1'b1;

        bl[0] = 32'h43423234; br[0] = 32'h0A4CD995; bc[0] = 64'h85E813540F0AB405;
        bl[1] = 32'h01000000; br[1] = 32'h00000000; bc[1] = 64'h8000000000000000;
        bl[2] = 32'h00000000; br[2] = 32'h00000001; bc[2] = 64'h0100000000000000;
        bl[3] = 32'h80000000; br[3] = 32'h00000000; bc[3] = 64'h0000000000000080;

        // Known DES vector, 8 back-to-back bytes.
        mark_first = 1'b1;
        send_burst(1);
        wait_drain();
        chk("vecA_span", 64'(last_cyc - first_cyc), 64'd7);
        chk("blk_cnt_1", {48'd0, blk_cnt}, 64'd1);

        bl[0] = bl[1]; br[0] = br[1]; bc[0] = bc[1];
        send_burst(1);
        wait_drain();
        chk("blk_cnt_2", {48'd0, blk_cnt}, 64'd2);

        // Downstream stalls on the known vector.
        bl[0] = 32'h43423234; br[0] = 32'h0A4CD995; bc[0] = 64'h85E813540F0AB405;
        stall_mode = 1'b1;
        send_burst(1);
        wait_drain();
        stall_mode = 1'b0;
        chk("blk_cnt_3", {48'd0, blk_cnt}, 64'd3);

        // Chained blocks with in_valid held high: no bubble between them.
        bl[1] = 32'h01000000; br[1] = 32'h00000000; bc[1] = 64'h8000000000000000;
        @(posedge clk);
        #1;
        mark_first = 1'b1;
        send_burst(4);
        wait_drain();
        chk("burst_span", 64'(last_cyc - first_cyc), 64'd31);
        chk("blk_cnt_7", {48'd0, blk_cnt}, 64'd7);

        // Reset after byte 3 discards the block.
        base = xfer_n;
        send_burst(1);
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (xfer_n >= base + 4) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("midrst_timeout", 64'd0, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_blk_cnt",   {48'd0, blk_cnt},   64'd0);
        chk("midrst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("midrst_byte_out",  {56'd0, byte_out},  64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bl[0] = bl[1]; br[0] = br[1]; bc[0] = bc[1];
        send_burst(1);
        wait_drain();
        chk("post_rst_blk_cnt", {48'd0, blk_cnt}, 64'd1);

        // Counter wrap: start from the last value before rollover.
        force dut.blk_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.blk_cnt_q;
        bl[0] = bl[2]; br[0] = br[2]; bc[0] = bc[2];
        send_burst(1);
        wait_drain();
        chk("blk_cnt_wrap", {48'd0, blk_cnt}, 64'd0);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
